pio_edge_capture_in: RTL and testbench
======================================

# pio_edge_capture_in

Avalon-MM slave input port that reads status lines from the convolution filter datapath into the Nios II processor. It is the input-side counterpart of the system's output PIO registers: it synchronises an asynchronous input bus, captures edges into sticky bits, and raises a maskable interrupt. Software polls it or takes the interrupt, for example to detect "frame done" or "FIFO overflow" from the filter.

## Interface
- WIDTH, 8, number of input lines (1..32)
- EDGE_TYPE, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address of the register
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, fixed read latency 1
- in_port  in  WIDTH  asynchronous input lines
- irq  out  1  level interrupt to the Nios II

## Operation
- Reset is `reset_n`, asynchronous, active-low, on clock `clk`. All flops clear on reset: sync stages, previous-value stage, capture, irqmask and readdata.
- Synchroniser: each bit passes through two flops, s1 then s2. A third flop, s3, holds the previous value of s2.
- Edge detect per bit, from s2 and s3:
  - EDGE_TYPE 0: s2 & ~s3
  - EDGE_TYPE 1: ~s2 & s3
  - EDGE_TYPE 2: s2 ^ s3
- Register map (address):
  - 0 data: read returns s2, zero-extended. Writes are ignored.
  - 1 direction: reads 0. Writes are ignored.
  - 2 irqmask: read/write, bits [WIDTH-1:0].
  - 3 edgecapture: read returns the sticky bits. Writing a 1 to a bit clears it (write-1-to-clear).
- Bits at or above WIDTH read 0 in every register.
- Access qualification:
  - Write when chipselect & ~write_n.
  - Read when chipselect & ~read_n.
  - Read and write asserted together: the write takes effect and readdata returns the pre-write value.
- Capture update per bit: next = (cap & ~clr) | det.
  - A set in the same cycle as a clear wins, so no edge is lost.
- irq = |(capture & irqmask). It is combinational from registers, with no extra flop.

## Timing
- in_port change stable before clock edge 1:
  - s1 updates at edge 1, s2 at edge 2.
  - det is high between edges 2 and 3.
  - capture sets at edge 3, and irq rises right after edge 3.
- Data register shows a new input value 2 cycles after sampling.
- Read is issued in cycle n. readdata is registered and valid in cycle n+1. readdata holds its value until the next read; non-read cycles do not clear it.
- irqmask write is visible to irq in the cycle after the write edge.
- Edgecapture clear: capture drops at the write edge, and irq falls in the same cycle unless another masked bit is set.
- Pulse narrower than one clk period: may be missed. This is not required to be captured.
- Reset asserted mid-operation: all state clears at once. After release, s3 starts at 0, so an input already high gives a rising edge 3 cycles later (EDGE_TYPE 0 or 2).

## Configuration
- Macro `PIO_EDGE_CAPTURE_IN_IRQ_EN`.
- Defined: irqmask register and the irq output logic are present, as described above.
- Not defined:
  - irqmask is not implemented; address 2 reads 0 and writes are ignored.
  - irq is tied to 0.
  - Edge capture stays in place for polling.

## Structure
- Shared package holds:
  - Address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - The EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, `sync_edge_det`: parameterised WIDTH and EDGE_TYPE. It contains the s1/s2/s3 chain and outputs the synchronised value and det.
- Top level holds the register file, read mux, readdata flop and irq.

## Test plan
- Reset check (WIDTH=8, EDGE_TYPE=0): hold reset_n low with in_port=0xFF, release, then read address 0 at cycle 4 -> readdata=0x000000FF. Read address 3 -> 0x000000FF, since a rising edge is seen out of reset.
- Rising capture plus irq: write irqmask=0x01, take in_port bit0 from 0 to 1 -> irq high 3 cycles later. Read address 3 -> 0x01. Write 0x01 to address 3 -> irq low the next cycle, and address 3 reads 0x00.
- Clear/set collision: a new rising edge on bit2 in the same cycle as a write of 0x04 to address 3 -> bit2 stays 1.
- Mask gating: capture=0x10 with irqmask=0x00 -> irq=0. Write irqmask=0x10 -> irq=1 the next cycle. Write irqmask=0x00 -> irq=0.
- EDGE_TYPE=2: toggle bit7 from 1 to 0 -> capture=0x80. Read address 1 -> 0. Read with chipselect=0 -> readdata does not change.
- Macro undefined: capture=0x01 with any write to address 2 -> address 2 reads 0 and irq stays 0.

Source files
------------

// File: rtl/pio_edge_capture_in_pkg.sv
// Shared constants for the edge-capturing input PIO.
// Register addresses and EDGE_TYPE encodings.
package pio_edge_capture_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_DIR     = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/pio_edge_capture_in_sync_edge_det.sv
// Two-flop synchroniser plus previous-value stage and
// per-bit edge detector for the input PIO.
module sync_edge_det
  import pio_edge_capture_in_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] det
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;

  // s3 is s2 delayed by one cycle, so s2 vs s3 is a clean edge
  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign det = ~s2 & s3;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign det = s2 ^ s3;
    end else begin : g_rise
      assign det = s2 & ~s3;
    end
  endgenerate

endmodule

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO with sticky edge capture and maskable irq.
// Optional irqmask/irq logic under PIO_EDGE_CAPTURE_IN_IRQ_EN.
module pio_edge_capture_in
  import pio_edge_capture_in_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask_q;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             rd;
  logic             unused_wdata;

  sync_edge_det #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync),
    .det     (det)
  );

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;

  assign clr = (wr && address == ADDR_EDGECAP) ?
               writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as a clear must survive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~clr) | det;
    end
  end

`ifdef PIO_EDGE_CAPTURE_IN_IRQ_EN
  logic [WIDTH-1:0] irqmask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr && address == ADDR_IRQMASK) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign mask_q = irqmask;
  assign irq    = |(capture & irqmask);
`else
  assign mask_q = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (address == ADDR_DATA):    rd_mux[WIDTH-1:0] = sync;
      (address == ADDR_DIR):     rd_mux = '0;
      (address == ADDR_IRQMASK): rd_mux[WIDTH-1:0] = mask_q;
      (address == ADDR_EDGECAP): rd_mux[WIDTH-1:0] = capture;
      default:                   rd_mux = '0;
    endcase
  end

  // readdata only changes on a read, so it holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd) begin
      readdata <= rd_mux;
    end
  end

  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Self-checking bench: rising and any-edge instances on one bus,
// directed scenarios plus random traffic against a history model.
module tb_pio_edge_capture_in;

`ifdef PIO_EDGE_CAPTURE_IN_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd_r, rd_a;
  logic        irq_r, irq_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r), .in_port(in_port),
    .irq(irq_r)
  );

  pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_port),
    .irq(irq_a)
  );

  // Model: h1/h2 are in_port as sampled two and three edges back
  logic [7:0]  h0, h1, h2;
  logic [7:0]  m_cap_r, m_cap_a, m_mask;
  logic [31:0] m_rd_r, m_rd_a;
  logic        m_irq_r, m_irq_a;

  assign m_irq_r = EN && ((m_cap_r & m_mask) != 8'h00);
  assign m_irq_a = EN && ((m_cap_a & m_mask) != 8'h00);

  function automatic logic [31:0] m_read(input logic [1:0] a,
                                         input logic [7:0] cap);
    case (a)
      2'd0:    return {24'h0, h1};
      2'd1:    return 32'h0;
      2'd2:    return EN ? {24'h0, m_mask} : 32'h0;
      default: return {24'h0, cap};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_cap_r <= '0; m_cap_a <= '0; m_mask <= '0;
      m_rd_r <= '0; m_rd_a <= '0;
    end else begin
      logic [7:0] clr;
      clr = (chipselect && !write_n && address == 2'd3) ?
            writedata[7:0] : 8'h00;
      if (chipselect && !read_n) begin
        m_rd_r <= m_read(address, m_cap_r);
        m_rd_a <= m_read(address, m_cap_a);
      end
      if (EN && chipselect && !write_n && address == 2'd2)
        m_mask <= writedata[7:0];
      m_cap_r <= (m_cap_r & ~clr) | (h1 & ~h2);
      m_cap_a <= (m_cap_a & ~clr) | (h1 ^ h2);
      h0 <= in_port;
      h1 <= h0;
      h2 <= h1;
    end
  end

  task automatic bus(input logic cs, input logic rd, input logic wr,
                     input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; read_n = ~rd; write_n = ~wr;
    address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    in_port = 8'hFF;
    wait_cycles(3);
    checks++;
    if (rd_r !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: got %h expected %h", rd_r, 32'h0);
    end
    checks++;
    if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b/%b expected 0/0", irq_r, irq_a);
    end
    reset_n = 1'b1;
    wait_cycles(3);
    bus(1, 1, 0, 2'd0, 0);
    checks++;
    if (rd_r !== 32'hFF) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", rd_r, 32'hFF);
    end
    bus(1, 1, 0, 2'd3, 0);
    checks++;
    if (rd_r !== 32'hFF || rd_a !== 32'hFF) begin
      errors++;
      $display("FAIL reset_cap: got %h/%h expected ff/ff", rd_r, rd_a);
    end
  endtask

  task automatic test_rise_irq;
    in_port = 8'h00;
    wait_cycles(4);
    bus(1, 0, 1, 2'd2, 32'h01);
    bus(1, 0, 1, 2'd3, 32'hFF);
    checks++;
    if (irq_r !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_idle: got %b expected 0", irq_r);
    end
    in_port = 8'h01;
    wait_cycles(2);
    checks++;
    if (irq_r !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_early: got %b expected 0", irq_r);
    end
    wait_cycles(1);
    checks++;
    if (irq_r !== EN || irq_a !== EN) begin
      errors++;
      $display("FAIL rise_irq_set: got %b/%b expected %b", irq_r, irq_a, EN);
    end
    bus(1, 1, 0, 2'd3, 0);
    checks++;
    if (rd_r !== 32'h01 || rd_a !== 32'h01) begin
      errors++;
      $display("FAIL rise_cap: got %h/%h expected 01/01", rd_r, rd_a);
    end
    bus(1, 0, 1, 2'd3, 32'h01);
    checks++;
    if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_clr: got %b/%b expected 0/0", irq_r, irq_a);
    end
    bus(1, 1, 0, 2'd3, 0);
    checks++;
    if (rd_r !== 32'h00) begin
      errors++;
      $display("FAIL rise_cap_clr: got %h expected %h", rd_r, 32'h0);
    end
  endtask

  task automatic test_collision;
    in_port = 8'h05;
    wait_cycles(2);
    bus(1, 0, 1, 2'd3, 32'h04);
    bus(1, 1, 0, 2'd3, 0);
    checks++;
    if (rd_r !== 32'h04 || rd_a !== 32'h04) begin
      errors++;
      $display("FAIL collision: got %h/%h expected 04/04", rd_r, rd_a);
    end
    bus(1, 0, 1, 2'd3, 32'hFF);
  endtask

  task automatic test_mask;
    bus(1, 0, 1, 2'd2, 32'h00);
    in_port = 8'h15;
    wait_cycles(4);
    checks++;
    if (irq_r !== 1'b0) begin
      errors++;
      $display("FAIL mask_off: got %b expected 0", irq_r);
    end
    bus(1, 0, 1, 2'd2, 32'h10);
    checks++;
    if (irq_r !== EN) begin
      errors++;
      $display("FAIL mask_on: got %b expected %b", irq_r, EN);
    end
    bus(1, 1, 0, 2'd2, 0);
    checks++;
    if (rd_r !== (EN ? 32'h10 : 32'h0)) begin
      errors++;
      $display("FAIL mask_read: got %h expected %h", rd_r,
               EN ? 32'h10 : 32'h0);
    end
    bus(1, 0, 1, 2'd2, 32'h00);
    checks++;
    if (irq_r !== 1'b0) begin
      errors++;
      $display("FAIL mask_clear: got %b expected 0", irq_r);
    end
  endtask

  task automatic test_any_edge;
    in_port = 8'h95;
    wait_cycles(4);
    bus(1, 0, 1, 2'd3, 32'hFF);
    in_port = 8'h15;
    wait_cycles(4);
    bus(1, 1, 0, 2'd3, 0);
    checks++;
    if (rd_a !== 32'h80 || rd_r !== 32'h00) begin
      errors++;
      $display("FAIL any_fall: got %h/%h expected 80/00", rd_a, rd_r);
    end
    bus(1, 1, 0, 2'd1, 0);
    checks++;
    if (rd_a !== 32'h0) begin
      errors++;
      $display("FAIL dir_read: got %h expected %h", rd_a, 32'h0);
    end
    bus(1, 1, 0, 2'd3, 0);
    bus(0, 1, 0, 2'd0, 0);
    wait_cycles(1);
    checks++;
    if (rd_a !== 32'h80) begin
      errors++;
      $display("FAIL cs_hold: got %h expected %h", rd_a, 32'h80);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      int r;
      checks++;
      if (rd_r !== m_rd_r) begin
        errors++;
        $display("FAIL rnd_rd_rise@%0d: got %h expected %h", i, rd_r, m_rd_r);
      end
      checks++;
      if (rd_a !== m_rd_a) begin
        errors++;
        $display("FAIL rnd_rd_any@%0d: got %h expected %h", i, rd_a, m_rd_a);
      end
      checks++;
      if (irq_r !== m_irq_r || irq_a !== m_irq_a) begin
        errors++;
        $display("FAIL rnd_irq@%0d: got %b/%b expected %b/%b",
                 i, irq_r, irq_a, m_irq_r, m_irq_a);
      end
      reset_n = (i != 200);
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      r = $urandom_range(0, 9);
      chipselect = (r >= 4) || ($urandom_range(0, 3) == 0);
      read_n = !(r inside {[4:6], 9} || r == 1);
      write_n = !(r inside {7, 8, 9} || r == 2);
      address = 2'($urandom);
      writedata = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rise_irq();
    test_collision();
    test_mask();
    test_any_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
